// File: rtl/mmio_pkg.sv
// Shared definitions for the data-memory MMIO window.
// Holds the register offsets inside the 16-word window and the bit
// positions of the timer control register.
package mmio_pkg;

    // Register offsets (address[3:0]) inside the MMIO window
    localparam logic [3:0] OFF_IN0      = 4'd0;   // inputs occupy 0..3
    localparam logic [3:0] OFF_OUT0     = 4'd4;   // outputs occupy 4..7
    localparam logic [3:0] OFF_STATUS   = 4'd8;
    localparam logic [3:0] OFF_IRQ_MASK = 4'd9;
    localparam logic [3:0] OFF_TCOUNT   = 4'd10;
    localparam logic [3:0] OFF_TCMP     = 4'd11;
    localparam logic [3:0] OFF_TCTRL    = 4'd12;

    // TCTRL bit positions
    localparam int TCTRL_EN         = 0;
    localparam int TCTRL_AUTORELOAD = 1;
    localparam int TCTRL_MATCH      = 2;
    localparam int TCTRL_MATCH_IE   = 3;

endpackage

// File: rtl/data_memory_mmio_if.sv
// CPU load/store bus between the datapath and the data memory / MMIO block.
// Signals:
//   address      - word address driven by the CPU
//   write_data   - store data
//   write_enable - store strobe
//   read_data    - load data, combinational from address
// Modports: master = CPU side, slave = memory/MMIO side.
interface data_memory_mmio_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  write_data;
    logic              write_enable;
    logic [WIDTH-1:0]  read_data;

    modport master (
        output address,
        output write_data,
        output write_enable,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        output read_data
    );
endinterface

// File: rtl/memory.sv
// Data memory: one write port clocked on the rising edge, asynchronous
// (combinational) read so a load returns data in the same cycle as its
// address. Contents are not reset.
// Ports:
//   clock        - system clock
//   address      - word address
//   write_data   - store data
//   write_enable - store strobe
//   read_data    - load data
module memory #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              write_enable,
    output logic [WIDTH-1:0]  read_data
);
    logic [WIDTH-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            r_mem[address] <= write_data;
        end
    end

    assign read_data = r_mem[address];
endmodule

// File: rtl/mmio_timer.sv
// Prescaled timer with compare match for the MMIO window.
// A prescaler counts 0..PRESCALE-1 while EN is set and ticks on wrap.
// Each tick either raises MATCH (count == compare) or advances the count.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   i_wr_count/cmp/ctrl   - one-cycle write strobes for TCOUNT/TCMP/TCTRL
//   i_wdata               - write data shared by the three registers
//   o_count, o_cmp, o_ctrl- register read-back values
//   o_irq                 - MATCH & MATCH_IE
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_count,
    input  logic             i_wr_cmp,
    input  logic             i_wr_ctrl,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_cmp,
    output logic [WIDTH-1:0] o_ctrl,
    output logic             o_irq
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_cmp;
    logic             r_en;
    logic             r_autoreload;
    logic             r_match;
    logic             r_match_ie;
    logic             w_tick;
    logic             w_hit;

    assign w_tick = r_en && (r_pre == PRE_LAST);
    assign w_hit  = w_tick && (r_count == r_cmp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (!r_en || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // CPU write has priority over both reload and increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_wr_count) begin
            r_count <= i_wdata;
        end else if (w_hit) begin
            if (r_autoreload) begin
                r_count <= '0;
            end
        end else if (w_tick) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp <= '1;
        end else if (i_wr_cmp) begin
            r_cmp <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_match      <= 1'b0;
            r_match_ie   <= 1'b0;
        end else begin
            // A CPU write to TCTRL overrides the one-shot auto-clear of EN
            if (i_wr_ctrl) begin
                r_en         <= i_wdata[TCTRL_EN];
                r_autoreload <= i_wdata[TCTRL_AUTORELOAD];
                r_match_ie   <= i_wdata[TCTRL_MATCH_IE];
            end else if (w_hit && !r_autoreload) begin
                r_en <= 1'b0;
            end
            // A new match wins over a same-cycle write-1-to-clear
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (i_wr_ctrl && i_wdata[TCTRL_MATCH]) begin
                r_match <= 1'b0;
            end
        end
    end

    always_comb begin
        o_ctrl                   = '0;
        o_ctrl[TCTRL_EN]         = r_en;
        o_ctrl[TCTRL_AUTORELOAD] = r_autoreload;
        o_ctrl[TCTRL_MATCH]      = r_match;
        o_ctrl[TCTRL_MATCH_IE]   = r_match_ie;
    end

    assign o_count = r_count;
    assign o_cmp   = r_cmp;
    assign o_irq   = r_match & r_match_ie;
endmodule

// File: rtl/data_memory_mmio.sv
// Data memory with a 16-word MMIO window for board I/O.
// Window stores never reach the memory; window loads return MMIO registers.
// Features: synchronised input ports, output registers, sticky input-change
// STATUS with mask, prescaled timer with compare, interrupt output.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   bus          - CPU load/store bus (slave side)
//   i_in_ports   - raw asynchronous inputs, port i at [i*WIDTH +: WIDTH]
//   o_out_ports  - output registers, same packing
//   o_irq        - OR of unmasked STATUS bits and timer match
module data_memory_mmio
    import mmio_pkg::*;
#(
    parameter int                WIDTH     = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFFF0,
    parameter int                NUM_IN    = 2,
    parameter int                NUM_OUT   = 2,
    parameter int                PRESCALE  = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    data_memory_mmio_if.slave        bus,
    input  logic [NUM_IN*WIDTH-1:0]  i_in_ports,
    output logic [NUM_OUT*WIDTH-1:0] o_out_ports,
    output logic                     o_irq
);
    logic              w_win;
    logic [3:0]        w_off;
    logic              w_we;
    logic              w_mem_we;
    logic [WIDTH-1:0]  w_mem_rdata;
    logic [WIDTH-1:0]  w_mmio_rdata;
    logic [3:0][WIDTH-1:0] w_in_pad;   // unused slots tie to 0 so they read 0
    logic [3:0][WIDTH-1:0] w_out_pad;
    logic [NUM_IN-1:0] w_change;
    logic [NUM_IN-1:0] w_status_clr;
    logic [NUM_IN-1:0] r_status;
    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  w_tcount;
    logic [WIDTH-1:0]  w_tcmp;
    logic [WIDTH-1:0]  w_tctrl;
    logic              w_timer_irq;

    assign w_win    = (bus.address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
    assign w_off    = bus.address[3:0];
    assign w_we     = bus.write_enable & w_win;
    assign w_mem_we = bus.write_enable & ~w_win;

    memory #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_memory (
        .clock        (clk),
        .address      (bus.address),
        .write_data   (bus.write_data),
        .write_enable (w_mem_we),
        .read_data    (w_mem_rdata)
    );

    // Input synchronisers; stage 3 only exists for change detection
    for (genvar gi = 0; gi < 4; gi++) begin : g_in
        if (gi < NUM_IN) begin : g_used
            logic [WIDTH-1:0] r_sync1;
            logic [WIDTH-1:0] r_sync2;
            logic [WIDTH-1:0] r_sync3;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= '0;
                    r_sync2 <= '0;
                    r_sync3 <= '0;
                end else begin
                    r_sync1 <= i_in_ports[gi*WIDTH +: WIDTH];
                    r_sync2 <= r_sync1;
                    r_sync3 <= r_sync2;
                end
            end

            assign w_in_pad[gi] = r_sync2;
            assign w_change[gi] = (r_sync2 != r_sync3);
        end else begin : g_unused
            assign w_in_pad[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_out
        if (gi < NUM_OUT) begin : g_used
            logic [WIDTH-1:0] r_out;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= '0;
                end else if (w_we && (w_off == OFF_OUT0 + 4'(gi))) begin
                    r_out <= bus.write_data;
                end
            end

            assign o_out_ports[gi*WIDTH +: WIDTH] = r_out;
            assign w_out_pad[gi]                  = r_out;
        end else begin : g_unused
            assign w_out_pad[gi] = '0;
        end
    end

    assign w_status_clr = (w_we && (w_off == OFF_STATUS)) ? bus.write_data[NUM_IN-1:0] : '0;

    // Set beats clear: the change term is OR-ed in after the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_status_clr) | w_change;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_we && (w_off == OFF_IRQ_MASK)) begin
            r_mask <= bus.write_data;
        end
    end

    mmio_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_wr_count (w_we && (w_off == OFF_TCOUNT)),
        .i_wr_cmp   (w_we && (w_off == OFF_TCMP)),
        .i_wr_ctrl  (w_we && (w_off == OFF_TCTRL)),
        .i_wdata    (bus.write_data),
        .o_count    (w_tcount),
        .o_cmp      (w_tcmp),
        .o_ctrl     (w_tctrl),
        .o_irq      (w_timer_irq)
    );

    always_comb begin
        w_mmio_rdata = '0;
        if (w_off[3:2] == OFF_IN0[3:2]) begin
            w_mmio_rdata = w_in_pad[w_off[1:0]];
        end else if (w_off[3:2] == OFF_OUT0[3:2]) begin
            w_mmio_rdata = w_out_pad[w_off[1:0]];
        end else begin
            case (w_off)
                OFF_STATUS:   w_mmio_rdata = WIDTH'(r_status);
                OFF_IRQ_MASK: w_mmio_rdata = r_mask;
                OFF_TCOUNT:   w_mmio_rdata = w_tcount;
                OFF_TCMP:     w_mmio_rdata = w_tcmp;
                OFF_TCTRL:    w_mmio_rdata = w_tctrl;
                default:      w_mmio_rdata = '0;
            endcase
        end
    end

    assign bus.read_data = w_win ? w_mmio_rdata : w_mem_rdata;

    // Only registered sources feed the interrupt
    assign o_irq = (|(r_status & r_mask[NUM_IN-1:0])) | w_timer_irq;
endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
Parametrised successor to the single-register memory-mapped data port. It wraps the existing data `memory` and decodes a 16-word MMIO window into several features:
- multiple synchronised input ports;
- multiple output registers;
- a sticky input-change status register;
- a prescaled timer with compare match;
- an interrupt output.

It sits between the CPU load/store datapath and the board I/O. CPU stores into the window never reach the data memory.

Parameters:
WIDTH, 16, data width of every port and register
ADDR_W, 16, address width
MMIO_BASE, 16'hFFF0, base of the 16-word MMIO window; low 4 bits must be 0
NUM_IN, 2, number of input ports (1..4)
NUM_OUT, 2, number of output registers (1..4)
PRESCALE, 1000, clock cycles per timer tick (>=1)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_ports  input  NUM_IN*WIDTH  raw asynchronous inputs (switches); port i = bits [i*WIDTH +: WIDTH]
write_data  input  WIDTH  CPU store data
address  input  ADDR_W  CPU word address
write_enable  input  1  CPU store strobe
read_data  output  WIDTH  CPU load data (combinational)
out_ports  output  NUM_OUT*WIDTH  output registers (LEDs), same packing as in_ports
irq  output  1  OR of unmasked status flags and timer match flag

Behaviour:
- Window hit: `in_win = (address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4])`. Offset = `address[3:0]`.
- Memory write gating: memory write enable = `write_enable & ~in_win`. Window stores never modify memory.
- Read mux:
  - `read_data` = MMIO register when `in_win`, else memory read data, same cycle as the address.
  - Unmapped offsets read 0. Writes to unmapped or read-only offsets are ignored.
- Register map (offset: function):
  - 0..NUM_IN-1: synchronised input i. Read-only.
  - 4..4+NUM_OUT-1: output register j, drives out_ports. Read/write.
  - 8 STATUS: bit i set when synchronised input i changes value. Write-1-to-clear.
  - 9 IRQ_MASK: bit i enables STATUS bit i onto irq. Read/write.
  - 10 TCOUNT: timer count. Read/write.
  - 11 TCMP: timer compare. Read/write.
  - 12 TCTRL: bit0 EN, bit1 AUTORELOAD, bit2 MATCH (write-1-to-clear), bit3 MATCH_IE. Other bits read 0.
- Input sync:
  - Two-flop synchroniser per input bit.
  - Reads see a raw input change 2 rising edges after it is sampled.
  - Change detect compares the sync stage-2 output with a third register. STATUS bit sets 1 cycle after the stage-2 value changes.
- Store timing: a store takes effect at the rising edge that ends the store cycle. A load in the next cycle returns the new value.
- Timer:
  - Prescale counter counts 0..PRESCALE-1 while EN=1 and emits a tick on wrap. It is cleared to 0 when EN=0.
  - On tick: if TCOUNT==TCMP, set MATCH. Then TCOUNT becomes 0 if AUTORELOAD=1; otherwise TCOUNT holds and EN clears. Otherwise TCOUNT increments, wrapping 16'hFFFF -> 0.
- irq = `|(STATUS & IRQ_MASK[NUM_IN-1:0]) | (MATCH & MATCH_IE)`. Registered sources, no combinational path from address.
- Simultaneous events:
  - A set event beats a W1C clear in the same cycle, for STATUS bits and MATCH.
  - A CPU write to TCOUNT beats a tick increment in the same cycle.
  - Writing TCTRL with EN=0 takes precedence over a same-cycle auto-clear.
- Reset values (async, immediate):
  - out_ports = 0
  - STATUS = 0, IRQ_MASK = 0
  - TCOUNT = 0, TCMP = 16'hFFFF, TCTRL = 0, prescaler = 0
  - sync flops = 0, irq = 0
  - Memory contents are not reset.
  - After reset release, STATUS may set once, 3 cycles later, if inputs are nonzero. This is expected; software clears it.
- Reset mid-timer: count and prescaler return to 0 and EN clears. No MATCH is generated.

Decomposition:
- Shared package `mmio_pkg` holds:
  - offset constants OFF_IN0, OFF_OUT0, OFF_STATUS, OFF_IRQ_MASK, OFF_TCOUNT, OFF_TCMP, OFF_TCTRL;
  - TCTRL bit indices.
- One natural sub-module: `mmio_timer` (prescaler, count, compare, MATCH logic, write ports).
- Synchroniser and decode stay inline. The existing `memory` module is instantiated unchanged.

Test Plan:
- Reset with in_ports[15:0]=16'h00A5; load from 16'hFFF0 after 3 cycles -> read_data=16'h00A5. out_ports=0 and irq=0 during and after reset.
- Store 16'h1234 to 16'hFFF4, then load 16'hFFF4 -> read_data=16'h1234 and out_ports[15:0]=16'h1234. Memory word at 16'h00F4 is unchanged. Store 16'h5555 to 16'h0010, then load it -> 16'h5555.
- Set IRQ_MASK=16'h0001, clear STATUS, toggle in_ports bit 3 -> STATUS bit0 sets 3 cycles later and irq=1. Write 16'h0001 to STATUS -> irq=0. A clear coinciding with a new change leaves the bit set.
- PRESCALE=4, TCMP=3, TCTRL=16'h000B (EN, AUTORELOAD, MATCH_IE) -> MATCH and irq assert after 16 cycles and TCOUNT=0. Writing 16'h000F to TCTRL (MATCH W1C, other bits kept) clears irq.
- Same setup with AUTORELOAD=0 -> after match, EN reads 0 and TCOUNT holds at 3.
- Assert reset mid-count with TCOUNT=2 -> TCOUNT=0, TCTRL=0, irq=0 immediately, before any clock edge.
